// File: rtl/cabac_ctx_bank_if.sv
// Port bundle for the CABAC context bank: init control, initValue ROM and decoder access.
interface cabac_ctx_bank_if #(parameter int IDX_W = 6);
  logic             i_init_start;
  logic [5:0]       i_slice_qp;
  logic [1:0]       i_slice_type;
  logic             i_init_flag;
  logic [IDX_W+1:0] o_rom_addr;
  logic [7:0]       i_rom_data;
  logic             o_init_busy;
  logic             o_init_done;
  logic [IDX_W-1:0] i_rd_idx;
  logic [6:0]       o_rd_state;
  logic             i_wr_en;
  logic [IDX_W-1:0] i_wr_idx;
  logic [6:0]       i_wr_state;
  logic             i_save;
  logic             i_restore;

  modport master (
    output i_init_start, i_slice_qp, i_slice_type, i_init_flag, i_rom_data,
           i_rd_idx, i_wr_en, i_wr_idx, i_wr_state, i_save, i_restore,
    input  o_rom_addr, o_init_busy, o_init_done, o_rd_state
  );

  modport slave (
    input  i_init_start, i_slice_qp, i_slice_type, i_init_flag, i_rom_data,
           i_rd_idx, i_wr_en, i_wr_idx, i_wr_state, i_save, i_restore,
    output o_rom_addr, o_init_busy, o_init_done, o_rd_state
  );
endinterface

// File: rtl/cabac_ctx_bank.sv
// CABAC context-model store: streaming init from initValue ROM plus a shadow snapshot bank.
//   state | meaning
//   IDLE  | waiting for init_start; decoder access enabled
//   RUN   | issuing ROM addresses 0..CTX_COUNT-1, one per cycle
//   DRAIN | two cycles letting the last pipeline entries reach the bank
module cabac_ctx_bank #(
  parameter int CTX_COUNT = 42,
  parameter int IDX_W     = 6
) (
  input logic             clk,
  input logic             rst,
  cabac_ctx_bank_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [1:0]       I_SLICE  = 2'd2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CTX_COUNT - 1);
  localparam logic [IDX_W:0]   CTX_LIM  = (IDX_W+1)'(CTX_COUNT);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       type_q, type_d;
  logic [5:0]       qpc_q, qpc_d;
  logic             drain_q, drain_d;
  logic             done_q, done_d;
  logic             issue, start, busy;

  logic             v1, v2;
  logic [IDX_W-1:0] idx1, idx2;
  logic [7:0]       iv1;
  logic signed [6:0]  m1;
  logic signed [7:0]  n1, n2;
  logic signed [12:0] m_ext, q_ext, prod_d, prod2;
  logic signed [9:0]  p2, sum2;
  logic [6:0]       pre, init_state;

  logic [6:0] live   [CTX_COUNT];
  logic [6:0] shadow [CTX_COUNT];
  logic       wr_ok;

  assign start = bus.i_init_start;
  assign busy  = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      type_q  <= '0;
      qpc_q   <= '0;
      drain_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      type_q  <= type_d;
      qpc_q   <= qpc_d;
      drain_q <= drain_d;
      done_q  <= done_d;
    end
  end

  // A start pulse always wins, including mid-init where it restarts from index 0.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    type_d  = type_q;
    qpc_d   = qpc_q;
    drain_d = drain_q;
    done_d  = done_q;
    issue   = 1'b0;
    if (start) begin
      state_d = RUN;
      idx_d   = '0;
      type_d  = (bus.i_slice_type == I_SLICE) ? 2'd0 : (bus.i_init_flag ? 2'd2 : 2'd1);
      qpc_d   = (bus.i_slice_qp > 6'd51) ? 6'd51 : bus.i_slice_qp;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          issue = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = DRAIN;
            drain_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_q == 1'b0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            drain_d = drain_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign m1     = 7'({3'b000, iv1[7:4]} * 7'd5) - 7'd45;
  assign n1     = {1'b0, iv1[3:0], 3'b000} - 8'd16;
  assign m_ext  = {{6{m1[6]}}, m1};
  assign q_ext  = {7'b0, qpc_q};
  assign prod_d = m_ext * q_ext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      idx1  <= '0;
      idx2  <= '0;
      iv1   <= '0;
      prod2 <= '0;
      n2    <= '0;
    end else begin
      v1    <= issue;
      v2    <= v1 && !start;
      idx1  <= idx_q;
      idx2  <= idx1;
      iv1   <= bus.i_rom_data;
      prod2 <= prod_d;
      n2    <= n1;
    end
  end

  // Product fits 13b; after the floor shift it fits 10b with room for the offset.
  assign p2   = 10'(prod2 >>> 4);
  assign sum2 = p2 + {{2{n2[7]}}, n2};
  assign pre  = (sum2 < 10'sd1) ? 7'd1 : (sum2 > 10'sd126) ? 7'd126 : sum2[6:0];
  assign init_state = pre[6] ? {pre[5:0], 1'b1} : {~pre[5:0], 1'b0};

  assign wr_ok = bus.i_wr_en && ({1'b0, bus.i_wr_idx} < CTX_LIM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CTX_COUNT; i++) begin
        live[i]   <= '0;
        shadow[i] <= '0;
      end
    end else if (!start) begin
      if (busy) begin
        if (v2) live[idx2] <= init_state;
      end else if (bus.i_restore) begin
        live <= shadow;
      end else begin
        if (bus.i_save) shadow <= live;
        // Same-cycle save sees the value being written.
        if (wr_ok) begin
          live[bus.i_wr_idx] <= bus.i_wr_state;
          if (bus.i_save) shadow[bus.i_wr_idx] <= bus.i_wr_state;
        end
      end
    end
  end

  assign bus.o_rom_addr  = {type_q, idx_q};
  assign bus.o_init_busy = busy;
  assign bus.o_init_done = done_q;
  assign bus.o_rd_state  = ({1'b0, bus.i_rd_idx} < CTX_LIM) ? live[bus.i_rd_idx] : 7'd0;
endmodule
